regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (RegWriteSig/writeReg/writeData) among NUM_REQ writeback requesters: ALU result, memory load, jump-and-link.
- Each requester uses a valid/ready handshake; one grant per cycle, round-robin fairness.
- The granted write is registered and driven to the register file one cycle later.
- Exports a pending-write mask that hazard/stall logic uses to detect RAW conflicts against in-flight writebacks.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..4)
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
hold  input  1  suppresses all grants while high (register file not writable this cycle)
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ*ADDR_W  packed destination register; requester i at bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  packed write data, same packing as req_addr
req_ready  output  NUM_REQ  one-hot grant; at most one bit high per cycle
RegWriteSig  output  1  write strobe to register file, registered
writeReg  output  ADDR_W  write address to register file, registered
writeData  output  DATA_W  write data to register file, registered
grant_id  output  2  index of requester whose write is on the output this cycle, registered
pending_mask  output  32  bit r set if register r has a waiting request or is being written this cycle

Behaviour:
- Reset (async, any time):
  - RegWriteSig=0, writeReg=0, writeData=0, grant_id=0.
  - Round-robin pointer=0.
  - req_ready=0 while reset is asserted.
  - A request being granted in the cycle reset asserts is lost; the requester must re-present it.
- Handshake:
  - A transfer occurs on a rising edge where req_valid[i] && req_ready[i].
  - A requester holds valid, addr and data stable until its transfer; it must not drop valid before ready.
- Grant (combinational from registered pointer, req_valid and hold):
  - hold=1: req_ready=0.
  - Otherwise, grant the first valid requester searching from ptr, ptr+1, … mod NUM_REQ.
  - No valid requester: req_ready=0 and the pointer is unchanged.
- Pointer update on a transfer: ptr <= (granted index + 1) mod NUM_REQ.
- Output latency is exactly 1 cycle. On the edge after transfer:
  - writeReg, writeData and grant_id take the granted values.
  - RegWriteSig=1, unless req_addr==0, in which case RegWriteSig=0. The transfer is still acknowledged and the pointer still advances.
- Cycles with no transfer: RegWriteSig=0; writeReg, writeData and grant_id hold their previous values.
- Throughput: back-to-back transfers every cycle with no bubble.
- pending_mask (combinational):
  - Set bit req_addr[i] for every requester with req_valid[i]=1.
  - Set bit writeReg when RegWriteSig=1.
  - Bit 0 is always 0.
- Same address from two requesters: both are serviced in grant order; the later write wins in the register file.
- hold asserted mid-stream: the write already registered still completes that cycle; no new grant until hold drops.
- Reset deasserting: grants may begin on the first rising edge after reset deasserts.

Decomposition:
- Package regfile_pkg:
  - ADDR_W, DATA_W constants.
  - REG_ZERO = 0.
  - Requester index constants REQ_ALU=0, REQ_MEM=1, REQ_LINK=2.
  - Typedef wb_req_t {valid, addr, data}.
- One sub-module rr_arbiter (parameter N; inputs req, hold, ptr; outputs one-hot gnt and gnt_idx). The top holds the pointer, output registers and pending_mask.

Test Plan:
- Reset, then valid[0]=1, addr=20, data=50 -> ready[0]=1 that cycle; next cycle RegWriteSig=1, writeReg=20, writeData=50, grant_id=0; following cycle RegWriteSig=0.
- All three valid continuously (addr 1/2/3, data 11/22/33) -> grants 0,1,2,0 on successive cycles; outputs follow one cycle later with no bubbles.
- valid[1]=1 with addr=0, data=99 -> ready[1]=1; next cycle RegWriteSig=0; pointer advances to 2.
- hold=1 for 3 cycles with valid[2]=1 -> ready stays 0 and pending_mask bit of addr[2] stays set; hold drops -> grant to 2 in that cycle, write the next cycle.
- Reset asserted mid-stream, between edges, while RegWriteSig=1 -> all outputs 0 immediately (before the next edge); after release, the first grant goes to requester 0.
- valid[0] addr=7 data=1 and valid[1] addr=7 data=2 together, ptr=0 -> writes of 1 then 2 to reg 7; pending_mask[7] stays high until the second write's output cycle ends.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int REG_ZERO = 0;

  // Writeback requester slots on the shared write port
  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping mod N.
// Latency: purely combinational, zero cycles.
// Backpressure: hold forces an empty grant so no requester sees ready.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  input  logic         hold,
  input  logic [1:0]   ptr,
  output logic [N-1:0] gnt,
  output logic [1:0]   gnt_idx
);

  logic found;
  int   idx;

  // Scan N slots starting at ptr; the first valid one wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!hold && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates NUM_REQ writeback requesters onto the register file's single write port.
// Latency: one cycle from handshake to RegWriteSig/writeReg/writeData; one transfer per cycle.
// Backpressure: req_ready is a one-hot grant, withheld entirely while hold or reset is high.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = regfile_pkg::ADDR_W,
  parameter int DATA_W  = regfile_pkg::DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        RegWriteSig,
  output logic [ADDR_W-1:0]           writeReg,
  output logic [DATA_W-1:0]           writeData,
  output logic [1:0]                  grant_id,
  output logic [31:0]                 pending_mask
);

  logic [1:0]         rrPtr;
  logic [1:0]         nextPtr;
  logic [1:0]         gntIdx;
  logic [NUM_REQ-1:0] gnt;
  logic [ADDR_W-1:0]  selAddr;
  logic [DATA_W-1:0]  selData;

  // Reset is folded into hold so nobody sees ready while reset is asserted
  rr_arbiter #(.N(NUM_REQ)) uArb (
    .req     (req_valid),
    .hold    (hold | reset),
    .ptr     (rrPtr),
    .gnt     (gnt),
    .gnt_idx (gntIdx)
  );

  assign req_ready = gnt;
  assign nextPtr   = (gntIdx == 2'(NUM_REQ - 1)) ? 2'd0 : gntIdx + 2'd1;

  // Mux the granted requester's address and data
  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        selAddr = req_addr[i*ADDR_W +: ADDR_W];
        selData = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Register the granted write; writes to the zero register are acknowledged but not strobed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrPtr       <= 2'd0;
      RegWriteSig <= 1'b0;
      writeReg    <= '0;
      writeData   <= '0;
      grant_id    <= 2'd0;
    end else begin
      RegWriteSig <= 1'b0;
      if (|gnt) begin
        rrPtr       <= nextPtr;
        RegWriteSig <= (selAddr != ADDR_W'(REG_ZERO));
        writeReg    <= selAddr;
        writeData   <= selData;
        grant_id    <= gntIdx;
      end
    end
  end

  // Registers with a waiting request or an in-flight write; r0 never hazards
  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        pending_mask[req_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      end
    end
    if (RegWriteSig) begin
      pending_mask[writeReg] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  import regfile_pkg::*;

  localparam int NR = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              hold;
  logic [NR-1:0]     req_valid;
  logic [NR*5-1:0]   req_addr;
  logic [NR*32-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              RegWriteSig;
  logic [4:0]        writeReg;
  logic [31:0]       writeData;
  logic [1:0]        grant_id;
  logic [31:0]       pending_mask;

  regfile_write_arbiter #(.NUM_REQ(NR), .ADDR_W(5), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .RegWriteSig  (RegWriteSig),
    .writeReg     (writeReg),
    .writeData    (writeData),
    .grant_id     (grant_id),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  // Requester-side state: each slot is one wb_req_t the requester is presenting
  wb_req_t slot [NR];

  // Reference model state: what the register file port should show
  int          mPtr;
  bit          mWe;
  logic [4:0]  mReg;
  logic [31:0] mData;
  int          mId;

  int checks = 0;
  int errors = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic driveInputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = slot[i].valid;
      req_addr[i*5 +: 5]   = slot[i].addr;
      req_data[i*32 +: 32] = slot[i].data;
    end
  endtask

  function automatic int expGrant();
    if (reset || hold) return -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (mPtr + k) % NR;
      if (slot[idx].valid) return idx;
    end
    return -1;
  endfunction

  function automatic logic [31:0] expMask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NR; i++)
      if (slot[i].valid) m[slot[i].addr] = 1'b1;
    if (mWe) m[mReg] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic resetModel();
    mPtr  = 0;
    mWe   = 1'b0;
    mReg  = '0;
    mData = '0;
    mId   = 0;
  endtask

  task automatic checkOutputs(input string tag);
    checkVal({tag, ".we"},   {31'd0, RegWriteSig}, {31'd0, mWe});
    checkVal({tag, ".reg"},  {27'd0, writeReg},    {27'd0, mReg});
    checkVal({tag, ".data"}, writeData,            mData);
    checkVal({tag, ".id"},   {30'd0, grant_id},    32'(mId));
  endtask

  // One clock: check at the falling edge, then advance the model through the rising edge
  task automatic cycle(input string tag);
    int g;
    logic [NR-1:0] expRdy;
    driveInputs();
    @(negedge clk);
    g = expGrant();
    expRdy = '0;
    if (g >= 0) expRdy[g] = 1'b1;
    checkVal({tag, ".ready"}, {29'd0, req_ready}, {29'd0, expRdy});
    checkOutputs(tag);
    checkVal({tag, ".pmask"}, pending_mask, expMask());
    @(posedge clk);
    if (reset) begin
      resetModel();
    end else if (g >= 0) begin
      mWe   = (slot[g].addr != 5'(REG_ZERO));
      mReg  = slot[g].addr;
      mData = slot[g].data;
      mId   = g;
      mPtr  = (g + 1) % NR;
      slot[g].valid = 1'b0;
    end else begin
      mWe = 1'b0;
    end
    #1;
  endtask

  task automatic present(input int i, input logic [4:0] a, input logic [31:0] d);
    slot[i].valid = 1'b1;
    slot[i].addr  = a;
    slot[i].data  = d;
  endtask

  initial begin
    reset = 1'b1;
    hold  = 1'b0;
    for (int i = 0; i < NR; i++) slot[i] = '0;
    resetModel();
    driveInputs();
    repeat (2) cycle("rst");
    reset = 1'b0;

    // Single ALU write
    present(REQ_ALU, 5'd20, 32'd50);
    repeat (3) cycle("single");

    // All three requesters continuously: 0,1,2,0,... with no bubbles
    for (int n = 0; n < 7; n++) begin
      if (!slot[0].valid) present(REQ_ALU,  5'd1, 32'd11);
      if (!slot[1].valid) present(REQ_MEM,  5'd2, 32'd22);
      if (!slot[2].valid) present(REQ_LINK, 5'd3, 32'd33);
      cycle("b2b");
    end
    for (int i = 0; i < NR; i++) slot[i].valid = 1'b0;
    repeat (2) cycle("drain");

    // Write to r0 from the memory port
    present(REQ_MEM, 5'd0, 32'd99);
    repeat (2) cycle("zero");

    // Hold with the link port waiting
    present(REQ_LINK, 5'd9, 32'd77);
    hold = 1'b1;
    repeat (3) cycle("hold");
    hold = 1'b0;
    repeat (2) cycle("unhold");

    // Same destination from two ports
    while (mPtr != 0) begin
      present(REQ_LINK, 5'd4, 32'd5);
      cycle("align");
    end
    present(REQ_ALU, 5'd7, 32'd1);
    present(REQ_MEM, 5'd7, 32'd2);
    repeat (4) cycle("samereg");

    // Reset between edges while a write is on the port
    present(REQ_MEM, 5'd12, 32'hABCD);
    cycle("prerst");
    checkVal("prerst.we_high", {31'd0, RegWriteSig}, 32'd1);
    present(REQ_MEM, 5'd13, 32'h1234);
    present(REQ_LINK, 5'd14, 32'h5678);
    #2;
    reset = 1'b1;
    #1;
    resetModel();
    checkVal("asyncrst.ready", {29'd0, req_ready}, 32'd0);
    checkOutputs("asyncrst");
    cycle("inrst");
    reset = 1'b0;
    present(REQ_ALU, 5'd15, 32'h9);
    repeat (4) cycle("postrst");

    // Randomized traffic with collisions, r0 writes and hold
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++)
        if (!slot[i].valid && ($urandom % 3 == 0))
          present(i, 5'($urandom % 8), $urandom);
      hold = ($urandom % 5 == 0);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
